// File: rtl/vc_wrr_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vc_wrr_arbiter_pkg : state encoding and shared defaults for the VC arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package vc_wrr_arbiter_pkg;

  typedef enum logic [0:0] {
    S_VC0 = 1'b0,
    S_VC1 = 1'b1
  } arb_state_e;

  localparam int DEST_BIT_DEF = 4;

  function automatic arb_state_e vc_to_state(input logic vc);
    return vc ? S_VC1 : S_VC0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vc_arb_eligible.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vc_arb_eligible : a VC may be granted when enabled, non-empty and its
//                   head word's destination FIFO is not almost full
// Rev 1.0
// ---------------------------------------------------------------------------
module vc_arb_eligible (
  input  logic enable_i,
  input  logic empty_i,
  input  logic dest_i,
  input  logic d0_af_i,
  input  logic d1_af_i,
  output logic elig_o
);

  assign elig_o = enable_i & ~empty_i & ~(dest_i ? d1_af_i : d0_af_i);

endmodule
`default_nettype wire

// File: rtl/vc_wrr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vc_wrr_arbiter : weighted round-robin drain of VC0/VC1 into the D0/D1 path
// Optional grant statistics: define ARB_STATS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module vc_wrr_arbiter
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int DATA_W     = 6,
  parameter int DEST_BIT   = DEST_BIT_DEF,
  parameter int CNT_W      = 3,
  parameter int VC0_WEIGHT = 4,
  parameter int VC1_WEIGHT = 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              arb_enable,
  input  logic              VC0_empty,
  input  logic              VC1_empty,
  input  logic [DATA_W-1:0] VC0_data_out,
  input  logic [DATA_W-1:0] VC1_data_out,
  input  logic              D0_almost_full,
  input  logic              D1_almost_full,
  output logic              VC0_rd,
  output logic              VC1_rd,
  output logic [DATA_W-1:0] arb_data_out,
  output logic              arb_valid_out,
  output logic              arb_vc_sel
`ifdef ARB_STATS_EN
  ,
  output logic [7:0]        vc0_grant_cnt,
  output logic [7:0]        vc1_grant_cnt
`endif
);

  localparam logic [CNT_W-1:0] W0 = CNT_W'(VC0_WEIGHT);
  localparam logic [CNT_W-1:0] W1 = CNT_W'(VC1_WEIGHT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              vc_sel_q, vc_sel_d;

  logic              elig0, elig1;
  logic              grant0, grant1, gnt_any, gnt_vc;
  logic [CNT_W-1:0]  gnt_weight, gnt_base, gnt_cnt;

  vc_arb_eligible u_elig0 (
    .enable_i (arb_enable),
    .empty_i  (VC0_empty),
    .dest_i   (VC0_data_out[DEST_BIT]),
    .d0_af_i  (D0_almost_full),
    .d1_af_i  (D1_almost_full),
    .elig_o   (elig0)
  );

  vc_arb_eligible u_elig1 (
    .enable_i (arb_enable),
    .empty_i  (VC1_empty),
    .dest_i   (VC1_data_out[DEST_BIT]),
    .d0_af_i  (D0_almost_full),
    .d1_af_i  (D1_almost_full),
    .elig_o   (elig1)
  );

  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_d    = state_q;
    burst_d    = burst_q;
    if (state_q == S_VC0) begin
      grant0 = elig0;
      grant1 = ~elig0 & elig1;
    end else begin
      grant1 = elig1;
      grant0 = ~elig1 & elig0;
    end
    gnt_any    = grant0 | grant1;
    gnt_vc     = grant1;
    gnt_weight = gnt_vc ? W1 : W0;
    // A fallback grant starts a fresh burst for the VC that was served.
    gnt_base   = (vc_to_state(gnt_vc) == state_q) ? burst_q : '0;
    gnt_cnt    = gnt_base + CNT_W'(1);
    if (gnt_any) begin
      if (gnt_cnt == gnt_weight) begin
        state_d = vc_to_state(~gnt_vc);
        burst_d = '0;
      end else begin
        state_d = vc_to_state(gnt_vc);
        burst_d = gnt_cnt;
      end
    end
    valid_d  = gnt_any;
    vc_sel_d = gnt_vc;
    data_d   = grant0 ? VC0_data_out : (grant1 ? VC1_data_out : '0);
  end

  assign VC0_rd = grant0 & reset_L;
  assign VC1_rd = grant1 & reset_L;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= S_VC0;
      burst_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      vc_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      vc_sel_q <= vc_sel_d;
    end
  end

  assign arb_data_out  = data_q;
  assign arb_valid_out = valid_q;
  assign arb_vc_sel    = vc_sel_q;

`ifdef ARB_STATS_EN
  logic [7:0] gcnt0_q, gcnt1_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (grant0 && gcnt0_q != 8'hFF) gcnt0_q <= gcnt0_q + 8'd1;
      if (grant1 && gcnt1_q != 8'hFF) gcnt1_q <= gcnt1_q + 8'd1;
    end
  end

  assign vc0_grant_cnt = gcnt0_q;
  assign vc1_grant_cnt = gcnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vc_wrr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vc_wrr_arbiter : directed bench with FIFO models and output scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vc_wrr_arbiter;

  localparam int W0 = 4;
  localparam int W1 = 1;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       arb_enable;
  logic       VC0_empty, VC1_empty;
  logic [5:0] VC0_data_out, VC1_data_out;
  logic       D0_almost_full, D1_almost_full;
  logic       VC0_rd, VC1_rd;
  logic [5:0] arb_data_out;
  logic       arb_valid_out, arb_vc_sel;
`ifdef ARB_STATS_EN
  logic [7:0] vc0_grant_cnt, vc1_grant_cnt;
`endif

  vc_wrr_arbiter dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .arb_enable     (arb_enable),
    .VC0_empty      (VC0_empty),
    .VC1_empty      (VC1_empty),
    .VC0_data_out   (VC0_data_out),
    .VC1_data_out   (VC1_data_out),
    .D0_almost_full (D0_almost_full),
    .D1_almost_full (D1_almost_full),
    .VC0_rd         (VC0_rd),
    .VC1_rd         (VC1_rd),
    .arb_data_out   (arb_data_out),
    .arb_valid_out  (arb_valid_out),
    .arb_vc_sel     (arb_vc_sel)
`ifdef ARB_STATS_EN
    ,
    .vc0_grant_cnt  (vc0_grant_cnt),
    .vc1_grant_cnt  (vc1_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       vc;
    logic [5:0] d;
  } exp_t;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  exp_t       sb[$];

  logic m_state;
  int   m_burst;
  int   m_cnt0, m_cnt1;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 1'b0;
    m_burst = 0;
    m_cnt0  = 0;
    m_cnt1  = 0;
  endtask

  // One arbitration cycle; starts 1 time unit after a rising edge.
  task automatic step(output logic g0, output logic g1);
    logic e0, e1, eg0, eg1;
    exp_t e;
    VC0_empty    = (q0.size() == 0);
    VC1_empty    = (q1.size() == 0);
    VC0_data_out = (q0.size() != 0) ? q0[0] : 6'd0;
    VC1_data_out = (q1.size() != 0) ? q1[0] : 6'd0;
    #2;
    e0 = arb_enable && !VC0_empty && !(VC0_data_out[4] ? D1_almost_full : D0_almost_full);
    e1 = arb_enable && !VC1_empty && !(VC1_data_out[4] ? D1_almost_full : D0_almost_full);
    if (m_state == 1'b0) begin
      eg0 = e0;
      eg1 = !e0 && e1;
    end else begin
      eg1 = e1;
      eg0 = !e1 && e0;
    end
    chk("VC0_rd", VC0_rd, eg0);
    chk("VC1_rd", VC1_rd, eg1);
    e.v  = eg0 | eg1;
    e.vc = eg1;
    e.d  = eg0 ? q0[0] : (eg1 ? q1[0] : 6'd0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (eg0) begin
      void'(q0.pop_front());
      if (m_cnt0 < 255) m_cnt0++;
    end
    if (eg1) begin
      void'(q1.pop_front());
      if (m_cnt1 < 255) m_cnt1++;
    end
    if (eg0 || eg1) begin
      if (eg1 == m_state) m_burst++;
      else begin
        m_state = eg1;
        m_burst = 1;
      end
      if (m_burst == (eg1 ? W1 : W0)) begin
        m_state = ~eg1;
        m_burst = 0;
      end
    end
    e = sb.pop_front();
    chk("arb_valid_out", arb_valid_out, e.v);
    chk("arb_vc_sel", arb_vc_sel, e.vc);
    chk("arb_data_out", arb_data_out, e.d);
`ifdef ARB_STATS_EN
    chk("vc0_grant_cnt", vc0_grant_cnt, m_cnt0);
    chk("vc1_grant_cnt", vc1_grant_cnt, m_cnt1);
`endif
    g0 = eg0;
    g1 = eg1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_VC0_rd"}, VC0_rd, 0);
    chk({tag, "_VC1_rd"}, VC1_rd, 0);
    chk({tag, "_data"}, arb_data_out, 0);
    chk({tag, "_valid"}, arb_valid_out, 0);
    chk({tag, "_vc_sel"}, arb_vc_sel, 0);
`ifdef ARB_STATS_EN
    chk({tag, "_cnt0"}, vc0_grant_cnt, 0);
    chk({tag, "_cnt1"}, vc1_grant_cnt, 0);
`endif
  endtask

  initial begin
    logic g0, g1;
    logic [1:0] pat2 [10];
    reset_L        = 1'b0;
    arb_enable     = 1'b1;
    D0_almost_full = 1'b0;
    D1_almost_full = 1'b0;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      q0.push_back(6'($urandom_range(0, 63)));
      q1.push_back(6'($urandom_range(0, 63)));
    end
    VC0_empty    = 1'b0;
    VC1_empty    = 1'b0;
    VC0_data_out = q0[0];
    VC1_data_out = q1[0];
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("por");
    reset_L = 1'b1;

    // Reset mid-burst, asserted between edges.
    step(g0, g1);
    step(g0, g1);
    #2;
    reset_L = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    reset_L = 1'b1;

    // Both VCs backlogged, weights 4/1; first grant after release is VC0.
    for (int i = 0; i < 10; i++) begin
      step(g0, g1);
      pat2[i] = {g1, g0};
    end
    chk("first_grant_after_reset", pat2[0], 2'b01);
    for (int i = 0; i < 10; i++)
      chk("wrr_pattern", pat2[i], ((i % 5) == 4) ? 2'b10 : 2'b01);

    // Disable mid-round: round resumes where it stopped.
    step(g0, g1); chk("pre_dis_g0", g0, 1);
    step(g0, g1); chk("pre_dis_g0", g0, 1);
    arb_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(g0, g1);
      chk("dis_no_grant", {g1, g0}, 2'b00);
    end
    chk("dis_valid_low", arb_valid_out, 0);
    arb_enable = 1'b1;
    step(g0, g1); chk("resume_g0_a", {g1, g0}, 2'b01);
    step(g0, g1); chk("resume_g0_b", {g1, g0}, 2'b01);
    step(g0, g1); chk("resume_g1", {g1, g0}, 2'b10);

    // VC0 empty, VC1 three words: back-to-back fallback grants.
    q0.delete();
    q1.delete();
    q1.push_back(6'h05);
    q1.push_back(6'h1A);
    q1.push_back(6'h2C);
    for (int i = 0; i < 3; i++) begin
      step(g0, g1);
      chk("vc1_only_grant", {g1, g0}, 2'b10);
    end
    step(g0, g1);
    chk("vc1_drained", {g1, g0}, 2'b00);
    chk("vc1_drained_valid", arb_valid_out, 0);

    // VC0 head bound for D1 which is almost full; VC1 head to D0 goes.
    q0.push_back(6'b010000);
    q1.push_back(6'b100000);
    D1_almost_full = 1'b1;
    step(g0, g1);
    chk("af_block_vc1", {g1, g0}, 2'b10);
    step(g0, g1);
    chk("af_block_none", {g1, g0}, 2'b00);
    D1_almost_full = 1'b0;
    step(g0, g1);
    chk("af_release_vc0", {g1, g0}, 2'b01);
    step(g0, g1);
    chk("af_release_idle", arb_valid_out, 0);

    // Long VC0-only run drives the VC0 grant counter into saturation.
    for (int i = 0; i < 300; i++) q0.push_back(6'(i));
    for (int i = 0; i < 300; i++) step(g0, g1);
    chk("long_run_drained", q0.size(), 0);
`ifdef ARB_STATS_EN
    chk("vc0_cnt_sat", vc0_grant_cnt, 8'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
